arduino_frame_rx: RTL
=====================

// Module: arduino_frame_rx
// PURPOSE
//  Receives one 256-bit display frame from the Arduino over a 3-wire link (arduino_clock, arduino_data,
//  arduino_latch) and presents it on the FPGA system clock domain.
//  Block sits upstream of the LED output path: it is the FPGA-side receiver for the Arduino-driven link.
//  All link inputs are asynchronous to clock. They are synchronised and edge-detected; they are never used as clocks.
// PARAMETERS
//  FRAME_BITS      256        bits per frame (>=2, power of 2 not required)
//  SYNC_STAGES     2          flip-flop stages in each input synchroniser (>=2)
//  TIMEOUT_CYCLES  1000000    clock cycles without an arduino_clock rise before a frame is aborted (timeout build only)
// PORTS
//  clock          in   1           system clock
//  reset_n        in   1           async active-low reset
//  arduino_clock  in   1           link bit clock, async; data sampled on its rising edge
//  arduino_data   in   1           link serial data, MSB first
//  arduino_latch  in   1           link frame sync, active high
//  frame_out      out  FRAME_BITS  last complete frame; bit FRAME_BITS-1 = first bit received
//  frame_valid    out  1           1-cycle pulse when frame_out updates
//  frame_error    out  1           1-cycle pulse on an aborted frame
//  busy           out  1           high while in RECV
// BEHAVIOUR
//  Reset: all outputs 0, shift reg 0, bit count 0, state IDLE, synchroniser flops 0. Reset is async assert, sync deassert.
//  Input path:
//   - Each input passes through SYNC_STAGES flops, then a 1-flop history register.
//   - clk_rise = sync & ~hist; lat_rise is formed the same way from arduino_latch.
//   - Data is taken from the synchronised arduino_data in the same cycle as clk_rise.
//   - Data and clock take equal delay, so no skew is introduced.
//  FSM states: IDLE, RECV.
//   - IDLE -> RECV on lat_rise: count <= 0.
//   - In IDLE, clk_rise is ignored.
//   - RECV, synced latch high: clk_rise is ignored (setup window).
//   - RECV, synced latch low, clk_rise:
//     - shift <= {shift[FRAME_BITS-2:0], data}; count++.
//     - If count == FRAME_BITS-1: frame_out <= completed shift value, frame_valid = 1 for one cycle, go to IDLE, count <= 0.
//   - RECV, lat_rise with count != 0: frame_error pulse, count <= 0, stay in RECV (new frame starts).
//   - RECV, lat_rise with count == 0: restart only, no error.
//  Simultaneous lat_rise and clk_rise in the same cycle: lat_rise wins and the bit is discarded.
//  Latency: the final-bit arduino_clock pin rise produces frame_valid exactly SYNC_STAGES+2 clock cycles later.
//  frame_out holds its value between frames; it is never partially updated; an aborted frame leaves it unchanged.
//  busy = (state == RECV).
//  Count width: $clog2(FRAME_BITS). Count never exceeds FRAME_BITS-1, so there is no wrap.
//  Link bit rate must satisfy: arduino_clock high and low times each >= SYNC_STAGES+1 clock periods.
//  Faster input is out of spec and gives undefined data; the FSM must not lock up.
// CONFIGURATION
//  ARDUINO_RX_TIMEOUT_EN defined:
//   - A watchdog counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering RECV and on every clk_rise, and increments otherwise in RECV.
//   - On reaching TIMEOUT_CYCLES: frame_error pulse, state IDLE, count 0.
//  ARDUINO_RX_TIMEOUT_EN undefined: no watchdog logic; RECV waits indefinitely for bits or latch.
// STRUCTURE
//  Package arduino_rx_pkg: rx_state_t enum {IDLE, RECV}; FRAME_BITS_DEF = 256; SYNC_STAGES_DEF = 2.
//  Sub-module sync_rise_det (params STAGES; ports clock, reset_n, d_async, q_sync, rise).
//  It is instantiated three times; the rise output of the data instance is unused.
// TESTING
//  1. Reset, then latch pulse, then 256 bits of 0xA5 pattern -> frame_valid pulses once, SYNC_STAGES+2 cycles after the last rise; frame_out = {32{8'hA5}}.
//  2. Latch, 100 bits, latch again, then 256 bits of all-ones -> frame_error pulse at the 2nd latch; frame_out = all ones; frame_valid pulses exactly once.
//  3. Latch and clock rise in the same synced cycle, then 256 bits -> first bit discarded; frame_out equals the 256 bits after the latch.
//  4. reset_n low asynchronously after bit 128 -> outputs 0 immediately; a full frame after release is received correctly.
//  5. With ARDUINO_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: latch, 10 bits, stall for 100 cycles -> frame_error, busy = 0, frame_out unchanged.
//     Without the macro, the same stall keeps busy = 1 and produces no error.
//  6. Clock edges with no latch in IDLE -> frame_valid and frame_error stay 0; busy stays 0.

Source files
------------

// File: rtl/arduino_rx_pkg.sv
// arduino_rx_pkg: shared state type and default sizing for the Arduino frame receiver.
package arduino_rx_pkg;
    typedef enum logic {IDLE, RECV} rx_state_t;
    localparam int FRAME_BITS_DEF  = 256;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: synchroniser plus history flop with a registered rising-edge flag.
// q_sync is the history flop, so it carries the same sample that produced the current rise.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic hist;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            hist <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d_async};
            hist <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~hist;
        end
    end
    assign q_sync = hist;
endmodule

// File: rtl/arduino_frame_rx.sv
// arduino_frame_rx: receives a FRAME_BITS serial frame over the Arduino 3-wire link into the clock domain.
// Optional ARDUINO_RX_TIMEOUT_EN adds a watchdog that aborts a stalled frame after TIMEOUT_CYCLES.
module arduino_frame_rx
    import arduino_rx_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arduino_clock,
    input  logic                  arduino_data,
    input  logic                  arduino_latch,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  busy
);
    localparam int CW = $clog2(FRAME_BITS);
    logic clk_s, clk_rise, lat_s, lat_rise, dat_s, data_rise_unused, timeout;
    rx_state_t state;
    logic [CW-1:0] count;
    logic [FRAME_BITS-1:0] shift, next_shift;

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_clk (.clock(clock), .reset_n(reset_n), .d_async(arduino_clock), .q_sync(clk_s), .rise(clk_rise));
    sync_rise_det #(.STAGES(SYNC_STAGES)) u_lat (.clock(clock), .reset_n(reset_n), .d_async(arduino_latch), .q_sync(lat_s), .rise(lat_rise));
    sync_rise_det #(.STAGES(SYNC_STAGES)) u_dat (.clock(clock), .reset_n(reset_n), .d_async(arduino_data), .q_sync(dat_s), .rise(data_rise_unused));

    assign next_shift = {shift[FRAME_BITS-2:0], dat_s};
    assign busy = state == RECV;

`ifdef ARDUINO_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;
    assign timeout = busy && wd == WW'(TIMEOUT_CYCLES);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wd <= '0;
        else wd <= (!busy || lat_rise || clk_rise || timeout) ? '0 : wd + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Latch rise has priority, so a bit arriving with it is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            shift       <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE) begin
                if (lat_rise) begin
                    state <= RECV;
                    count <= '0;
                end
            end else if (lat_rise) begin
                frame_error <= count != '0;
                count       <= '0;
            end else if (timeout) begin
                frame_error <= 1'b1;
                state       <= IDLE;
                count       <= '0;
            end else if (clk_rise && !lat_s) begin
                shift <= next_shift;
                if (count == CW'(FRAME_BITS - 1)) begin
                    frame_out   <= next_shift;
                    frame_valid <= 1'b1;
                    state       <= IDLE;
                    count       <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end
endmodule
